// File: rtl/pipe_pkg.sv
// Shared widths and types for the decode-stage register file and its scoreboard.
package pipe_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, and the RAW/WAW stall.
module rf_scoreboard #(
  parameter int ADDR_W = pipe_pkg::ADDR_W,
  parameter int NREGS  = pipe_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic              issue_en,
  input  logic              issue_rd_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              stall,
  output logic [NREGS-1:0]  busy_vec
);
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(pipe_pkg::REG_ZERO);

  logic [NREGS-1:0] busy_q, busy_nxt;
  logic raw1, raw2, waw, fire;

  // A writeback landing this cycle already resolves the hazard it clears.
  assign raw1  = rs1_used && busy_q[rs1_addr] && !(wr_en && wr_addr == rs1_addr);
  assign raw2  = rs2_used && busy_q[rs2_addr] && !(wr_en && wr_addr == rs2_addr);
  assign waw   = issue_rd_valid && busy_q[issue_rd] && !(wr_en && wr_addr == issue_rd);
  assign stall = issue_en && (raw1 || raw2 || waw);
  assign fire  = issue_en && !stall;

  always_comb begin
    busy_nxt = busy_q;
    if (wr_en && wr_addr != ZERO) busy_nxt[wr_addr] = 1'b0;
    // Set after clear: the newly issued producer owns the register.
    if (fire && issue_rd_valid && issue_rd != ZERO) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

  assign busy_vec = busy_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// Decode register file: two bypassed combinational read ports, one writeback port, busy scoreboard.
module regfile_scoreboard #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int ADDR_W = pipe_pkg::ADDR_W,
  parameter int NREGS  = pipe_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              rs1_used,
  input  logic              rs2_used,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              issue_en,
  input  logic              issue_rd_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              stall,
  output logic [NREGS-1:0]  busy_vec
);
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(pipe_pkg::REG_ZERO);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en && wr_addr != ZERO) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Write-first bypass; reads are forced to zero while reset is held.
  always_comb begin
    rs1_data = '0;
    if (rst_n && rs1_addr != ZERO)
      rs1_data = (wr_en && wr_addr == rs1_addr) ? wr_data : regs[rs1_addr];
  end

  always_comb begin
    rs2_data = '0;
    if (rst_n && rs2_addr != ZERO)
      rs2_data = (wr_en && wr_addr == rs2_addr) ? wr_data : regs[rs2_addr];
  end

  rf_scoreboard #(.ADDR_W(ADDR_W), .NREGS(NREGS)) u_sb (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rs1_used       (rs1_used),
    .rs2_used       (rs2_used),
    .issue_en       (issue_en),
    .issue_rd_valid (issue_rd_valid),
    .issue_rd       (issue_rd),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .stall          (stall),
    .busy_vec       (busy_vec)
  );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Random and directed stimulus against an array-based reference of the register file and scoreboard.
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, issue_rd, wr_addr;
  logic        rs1_used, rs2_used, issue_en, issue_rd_valid, wr_en;
  logic [31:0] wr_data, rs1_data, rs2_data;
  logic        stall;
  logic [31:0] busy_vec;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_stall;

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_en(issue_en), .issue_rd_valid(issue_rd_valid), .issue_rd(issue_rd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .stall(stall), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit pending(input logic [4:0] a);
    return m_busy[a] && !(wr_en && wr_addr == a);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (!rst_n || a == 0) return 32'h0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] m_busy_word();
    logic [31:0] w;
    for (int i = 0; i < 32; i++) w[i] = m_busy[i];
    return w;
  endfunction

  // Move to the falling edge and compare every output with the model.
  task automatic settle();
    #4;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
    end
    m_stall = rst_n && issue_en && ((rs1_used && pending(rs1_addr)) ||
                                    (rs2_used && pending(rs2_addr)) ||
                                    (issue_rd_valid && pending(issue_rd)));
    chk("rs1_data", rs1_data, m_read(rs1_addr));
    chk("rs2_data", rs2_data, m_read(rs2_addr));
    chk("stall", stall, m_stall);
    chk("busy_vec", busy_vec, m_busy_word());
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (wr_en && wr_addr != 0) begin m_regs[wr_addr] = wr_data; m_busy[wr_addr] = 0; end
      if (issue_en && !m_stall && issue_rd_valid && issue_rd != 0) m_busy[issue_rd] = 1;
    end
    #1;
  endtask

  task automatic idle();
    rs1_used = 0; rs2_used = 0; issue_en = 0; issue_rd_valid = 0; wr_en = 0;
    rs1_addr = 0; rs2_addr = 0; issue_rd = 0; wr_addr = 0; wr_data = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    idle(); issue_en = 1; issue_rd_valid = 1; issue_rd = rd;
    settle(); tick();
  endtask

  initial begin
    rst_n = 0; idle();
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
    #1; settle(); tick();
    rst_n = 1; settle(); tick();

    // Same-cycle bypass, then the stored value.
    idle(); wr_en = 1; wr_addr = 7; wr_data = 32'h12345678; rs1_addr = 7;
    settle(); chk("bypass_same_cycle", rs1_data, 32'h12345678); tick();
    wr_en = 0; settle(); chk("after_write", rs1_data, 32'h12345678); tick();

    // RAW on rs2, released by the matching writeback.
    issue(5'd3);
    idle(); issue_en = 1; rs2_addr = 3; rs2_used = 1;
    settle(); chk("raw_stall", stall, 1'b1); tick();
    settle(); chk("raw_stall_hold", stall, 1'b1); tick();
    wr_en = 1; wr_addr = 3; wr_data = 32'hA5;
    settle(); chk("raw_release", stall, 1'b0); chk("raw_bypass", rs2_data, 32'hA5); tick();

    // Unused operand on a busy register.
    issue(5'd4);
    idle(); issue_en = 1; rs1_addr = 4; rs1_used = 0;
    settle(); chk("unused_operand", stall, 1'b0); tick();

    // WAW stall, then set-wins against a same-cycle clear.
    issue(5'd9);
    idle(); issue_en = 1; issue_rd_valid = 1; issue_rd = 9;
    settle(); chk("waw_stall", stall, 1'b1); tick();
    chk("waw_busy_kept", busy_vec[9], 1'b1);
    wr_en = 1; wr_addr = 9; wr_data = 32'h99;
    settle(); chk("set_wins_stall", stall, 1'b0); tick();
    chk("set_wins_busy", busy_vec[9], 1'b1);

    // Stalled issue must not mark its destination.
    issue(5'd10);
    idle(); issue_en = 1; rs1_addr = 10; rs1_used = 1; issue_rd_valid = 1; issue_rd = 12;
    settle(); chk("stalled_stall", stall, 1'b1); tick();
    chk("stalled_no_mark", busy_vec[12], 1'b0);

    // Randomized traffic with small address range to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      rst_n          = ($urandom_range(0, 299) != 0);
      rs1_addr       = 5'($urandom_range(0, 7));
      rs2_addr       = 5'($urandom_range(0, 7));
      rs1_used       = 1'($urandom);
      rs2_used       = 1'($urandom);
      issue_en       = 1'($urandom);
      issue_rd_valid = 1'($urandom);
      issue_rd       = 5'($urandom_range(0, 7));
      wr_en          = 1'($urandom);
      wr_addr        = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wr_data        = $urandom;
      settle(); tick();
    end
    rst_n = 1;

    // Mid-run reset discards data and busy bits; x0 stays zero.
    idle(); wr_en = 1; wr_addr = 5; wr_data = 32'h55; settle(); tick();
    wr_addr = 31; wr_data = 32'h31; settle(); tick();
    issue(5'd6);
    idle(); rst_n = 0; wr_en = 1; wr_addr = 5; wr_data = 32'hFFFF; rs1_addr = 5; rs2_addr = 31;
    issue_en = 1; issue_rd_valid = 1; issue_rd = 6;
    settle();
    chk("rst_rs1", rs1_data, 32'h0); chk("rst_rs2", rs2_data, 32'h0);
    chk("rst_busy", busy_vec, 32'h0); chk("rst_stall", stall, 1'b0);
    tick();
    rst_n = 1; idle(); wr_en = 1; wr_addr = 0; wr_data = 32'hDEADBEEF; rs1_addr = 0; rs2_addr = 5;
    settle(); chk("x0_write_bypass", rs1_data, 32'h0); chk("r5_cleared", rs2_data, 32'h0); tick();
    wr_en = 0; settle(); chk("x0_after_write", rs1_data, 32'h0); tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Decode-stage register file with two combinational read ports and one write port.
- Includes a per-register busy scoreboard for RAW/WAW hazard stalls.
- rs1_data/rs2_data drive the two 32-bit operand inputs of the ID/EX pipeline register (dflipflop12), which captures them on the same clk edge.
- The write port is driven by the writeback stage.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- NREGS, 2**ADDR_W, register count; entry 0 is hardwired zero.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- rs1_addr  input  ADDR_W  read port 1 address.
- rs2_addr  input  ADDR_W  read port 2 address.
- rs1_used  input  1  instruction in decode actually reads rs1.
- rs2_used  input  1  instruction in decode actually reads rs2.
- rs1_data  output  DATA_W  read port 1 data, combinational.
- rs2_data  output  DATA_W  read port 2 data, combinational.
- issue_en  input  1  decode wants to issue its instruction this cycle.
- issue_rd_valid  input  1  issuing instruction writes a destination.
- issue_rd  input  ADDR_W  destination register of the issuing instruction.
- wr_en  input  1  writeback valid.
- wr_addr  input  ADDR_W  writeback destination.
- wr_data  input  DATA_W  writeback value.
- stall  output  1  decode must hold; issue is suppressed. Combinational.
- busy_vec  output  NREGS  scoreboard state (debug/verification).

Behaviour:
- Clocking and reset:
  - One clock, clk; reset rst_n is asynchronous, active-low.
  - On rst_n=0, immediately clear all registers to 0 and busy_vec to 0.
  - Outputs during reset: stall=0. rs1_data and rs2_data read 0 for any address (no bypass is applied while rst_n=0).
  - Reset asserted mid-operation discards any pending writes and busy bits.
- Writes:
  - At posedge, if wr_en=1 and wr_addr!=0, then regs[wr_addr] <= wr_data.
  - Writes to x0 are ignored.
  - Write latency is 1 cycle to the array. Bypass makes the value visible in the same cycle.
- Reads:
  - rsN_data = 0 if rsN_addr==0.
  - Otherwise, if wr_en and wr_addr==rsN_addr, rsN_data = wr_data (write-first bypass).
  - Otherwise rsN_data = regs[rsN_addr].
  - Both ports are independent; the same address on both ports is legal.
- Scoreboard:
  - busy[0] is constant 0.
  - clear_hit(a) = wr_en && wr_addr==a.
  - raw1 = rs1_used && busy[rs1_addr] && !clear_hit(rs1_addr). raw2 is defined likewise for port 2.
  - waw = issue_rd_valid && busy[issue_rd] && !clear_hit(issue_rd).
  - stall = issue_en && (raw1 || raw2 || waw).
  - Issue fires when issue_en && !stall.
  - At posedge, if wr_en and wr_addr!=0, then busy[wr_addr] <= 0.
  - At posedge, if issue fires and issue_rd_valid and issue_rd!=0, then busy[issue_rd] <= 1.
  - If set and clear hit the same register in the same cycle, set wins (new producer owns it).
- Invariants:
  - The WAW stall guarantees at most one outstanding producer per register.
  - A wr_en to a non-busy register is legal: data updates, busy stays 0.
  - An issue with issue_rd==0 never sets busy.
- The block has no internal FSM beyond the per-register busy bits; the ID/EX register downstream has no enable, so the decode stage inserts a bubble when stall=1.

Decomposition:
- Shared package pipe_pkg:
  - DATA_W, ADDR_W, NREGS constants.
  - reg_addr_t typedef (ADDR_W bits).
  - word_t typedef (DATA_W bits).
  - REG_ZERO constant = 0.
- One natural sub-module, rf_scoreboard: holds busy_vec, set/clear logic, and stall generation. The top level holds the array and the bypass muxes.

Test Plan:
- Reset and zero:
  - Stimulus: assert rst_n=0 mid-simulation after writes; read r5 and r31; then write x0=0xDEADBEEF and read x0.
  - Required: rs1_data=0 and rs2_data=0 during reset; busy_vec=0; x0 still reads 0 after the write.
- Write/read with bypass:
  - Stimulus: wr_en=1, wr_addr=7, wr_data=0x12345678, rs1_addr=7, same cycle.
  - Required: rs1_data=0x12345678 that cycle; next cycle with wr_en=0, rs1_data is still 0x12345678.
- RAW stall:
  - Stimulus: issue rd=3 (issue_en=1, issue_rd_valid=1); next cycle issue an instruction with rs2_addr=3, rs2_used=1.
  - Required: stall=1 while busy[3]=1. When wr_en with wr_addr=3 and wr_data=0xA5 arrives, stall=0 and rs2_data=0xA5 in that same cycle.
- Unused operand:
  - Stimulus: busy[4]=1; decode has rs1_addr=4, rs1_used=0.
  - Required: stall=0.
- WAW and set-wins:
  - Stimulus 1: busy[9]=1; issue with issue_rd=9. Required: stall=1 and busy[9] stays 1.
  - Stimulus 2: same cycle as wr_addr=9 writeback, issue rd=9. Required: stall=0 and busy[9]=1 after the edge.
- Stalled issue does not mark:
  - Stimulus: stall=1 due to rs1 RAW while issue_rd=12.
  - Required: busy[12] stays 0 after the edge.
